// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared state encoding, default frame length and counter sizing for spi_slave_rx
package spi_rx_pkg;
  localparam int DEFAULT_DATA_BITS = 24;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} spi_rx_state_e;
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_COMMIT = COMMIT;
  function automatic int cnt_width(input int data_bits);
    return $clog2(data_bits + 2);
  endfunction
endpackage

// File: rtl/spi_slave_rx_sync.sv
// sync_edge_detect: synchroniser with rise/fall strobes; SPI_RX_GLITCH_FILTER_EN adds a 3-sample majority filter
module sync_edge_detect
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic level, level_q;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) sync_q <= {SYNC_STAGES{RST_VAL}};
    else sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
`ifdef SPI_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) hist_q <= {2{RST_VAL}};
    else hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
  // a single-cycle excursion never wins two of the three samples
  assign level = (sync_q[SYNC_STAGES-1] & hist_q[0]) | (sync_q[SYNC_STAGES-1] & hist_q[1]) |
                 (hist_q[0] & hist_q[1]);
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) level_q <= RST_VAL;
    else level_q <= level;
  assign o_rise = level & ~level_q;
  assign o_fall = ~level & level_q;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receiver (CS low, SCK idle high, MSB first) with valid/ready output.
// SPI_RX_GLITCH_FILTER_EN enables SCK/CS majority filtering and one extra SDI alignment stage.
module spi_slave_rx
  import spi_rx_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_SPI_CS,
  input  logic                 i_SPI_clock,
  input  logic                 i_SPI_data,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic                 o_busy,
  output logic                 o_frame_error,
  output logic                 o_overrun
);
  localparam int CW = cnt_width(DATA_BITS);
`ifdef SPI_RX_GLITCH_FILTER_EN
  localparam int SDI_STAGES = SYNC_STAGES + 1;
`else
  localparam int SDI_STAGES = SYNC_STAGES;
`endif
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [SDI_STAGES-1:0] sdi_q;
  logic fall_pend, sck_fall, sck_rise_unused, cs_rise, cs_fall;
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sck (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_async(i_SPI_clock),
    .o_rise(sck_rise_unused), .o_fall(sck_fall)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_async(i_SPI_CS),
    .o_rise(cs_rise), .o_fall(cs_fall)
  );
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) sdi_q <= '0;
    else sdi_q <= {sdi_q[SDI_STAGES-2:0], i_SPI_data};
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      shreg <= '0;
      fall_pend <= 1'b0;
      o_data <= '0;
      o_data_valid <= 1'b0;
      o_busy <= 1'b0;
      o_frame_error <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_frame_error <= 1'b0;
      o_overrun <= 1'b0;
      if (o_data_valid && i_data_ready) o_data_valid <= 1'b0;
      case (state)
        ST_IDLE:
          if (cs_fall || fall_pend) begin
            state <= ST_SHIFT;
            cnt <= '0;
            shreg <= '0;
            fall_pend <= 1'b0;
            o_busy <= 1'b1;
          end
        ST_SHIFT:
          if (cs_rise) begin
            state <= ST_COMMIT;
            o_busy <= 1'b0;
          end else if (sck_fall) begin
            shreg <= {shreg[DATA_BITS-2:0], sdi_q[SDI_STAGES-1]};
            cnt <= (cnt == CW'(DATA_BITS + 1)) ? cnt : cnt + 1'b1;
          end
        ST_COMMIT: begin
          state <= ST_IDLE;
          // remember a select that reasserts during commit so IDLE still starts the frame
          fall_pend <= cs_fall;
          if (cnt == CW'(DATA_BITS)) begin
            if (o_data_valid && !i_data_ready) o_overrun <= 1'b1;
            else begin
              o_data <= shreg;
              o_data_valid <= 1'b1;
            end
          end else if (cnt != '0) o_frame_error <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: scoreboard bench for spi_slave_rx; honours SPI_RX_GLITCH_FILTER_EN
module tb_spi_slave_rx;
  localparam int SS = 2;
  localparam int HP = 10;
`ifdef SPI_RX_GLITCH_FILTER_EN
  localparam int LAT = SS + 2;
  localparam int GLITCH_ERR = 0;
`else
  localparam int LAT = SS + 1;
  localparam int GLITCH_ERR = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, cs = 1'b1, sck = 1'b1, sdi = 1'b0, rdy = 1'b0;
  logic [23:0] data;
  logic valid, busy, ferr, ovr;
  int n_cmp = 0, n_fail = 0, n_ferr = 0, n_ovr = 0, n_vcyc = 0;
  logic [23:0] q[$];
  logic pv = 1'b0;
  logic [23:0] pd = '0;

  spi_slave_rx #(.DATA_BITS(24), .SYNC_STAGES(SS)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_SPI_CS(cs), .i_SPI_clock(sck), .i_SPI_data(sdi),
    .o_data(data), .o_data_valid(valid), .i_data_ready(rdy), .o_busy(busy),
    .o_frame_error(ferr), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [23:0] exp_w;
    if (rst_n) begin
      if (ferr) n_ferr++;
      if (ovr) n_ovr++;
      if (valid) n_vcyc++;
      if (valid && (!pv || data != pd)) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL word_unexpected got %h want none", data);
        end else begin
          exp_w = q.pop_front();
          if (data !== exp_w) begin
            n_fail++;
            $display("FAIL word got %h want %h", data, exp_w);
          end
        end
      end
    end
    pv = valid;
    pd = data;
  end

  task automatic send_bits(input logic [31:0] w, input int n, input int glitch);
    @(negedge clk) cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      sdi = w[n-1-i];
      if (i == glitch) begin
        repeat (5) @(negedge clk);
        sck = 1'b0;
        @(negedge clk) sck = 1'b1;
        repeat (4) @(negedge clk);
      end else repeat (HP) @(negedge clk);
      sck = 1'b0;
      repeat (HP) @(negedge clk);
      sck = 1'b1;
    end
    repeat (HP) @(negedge clk);
  endtask

  task automatic end_frame(input bit pulse_ready);
    @(negedge clk) cs = 1'b1;
    if (pulse_ready) begin
      repeat (LAT) @(negedge clk);
      rdy = 1'b1;
      @(negedge clk) rdy = 1'b0;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (data !== 24'h0) begin n_fail++; $display("FAIL reset_data got %h want 000000", data); end
    n_cmp++;
    if ({valid, busy, ferr, ovr} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000", {valid, busy, ferr, ovr});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int f0 = n_ferr, o0 = n_ovr, v0 = n_vcyc;
    rdy = 1'b1;
    q.push_back(24'hA5C3F0);
    send_bits(32'hA5C3F0, 24, -1);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    end_frame(0);
    wait_drain();
    n_cmp++;
    if (q.size() != 0) begin n_fail++; $display("FAIL basic_drain got %0d pending want 0", q.size()); end
    n_cmp++;
    if (n_vcyc - v0 != 1) begin n_fail++; $display("FAIL basic_valid_cycles got %0d want 1", n_vcyc - v0); end
    n_cmp++;
    if (n_ferr != f0 || n_ovr != o0) begin
      n_fail++;
      $display("FAIL basic_pulses got err %0d ovr %0d want 0 0", n_ferr - f0, n_ovr - o0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_frame_error();
    int v0 = n_vcyc;
    for (int n = 23; n <= 25; n += 2) begin
      int f0 = n_ferr;
      send_bits(32'h1ABCDEF, n, -1);
      end_frame(0);
      n_cmp++;
      if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL ferr_%0d got %0d pulses want 1", n, n_ferr - f0); end
    end
    n_cmp++;
    if (data !== 24'hA5C3F0) begin n_fail++; $display("FAIL ferr_data got %h want a5c3f0", data); end
    n_cmp++;
    if (n_vcyc != v0) begin n_fail++; $display("FAIL ferr_valid got %0d cycles want 0", n_vcyc - v0); end
  endtask

  task automatic test_overrun();
    int o0 = n_ovr;
    rdy = 1'b0;
    q.push_back(24'h000001);
    send_bits(32'h000001, 24, -1);
    end_frame(0);
    send_bits(32'hFFFFFE, 24, -1);
    end_frame(0);
    n_cmp++;
    if (data !== 24'h000001) begin n_fail++; $display("FAIL ovr_data got %h want 000001", data); end
    n_cmp++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b want 1", valid); end
    n_cmp++;
    if (n_ovr - o0 != 1) begin n_fail++; $display("FAIL ovr_pulses got %0d want 1", n_ovr - o0); end
    rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept got %b want 0", valid); end
  endtask

  task automatic test_commit_ready();
    int o0 = n_ovr;
    rdy = 1'b0;
    q.push_back(24'h654321);
    send_bits(32'h654321, 24, -1);
    end_frame(0);
    q.push_back(24'h123456);
    send_bits(32'h123456, 24, -1);
    end_frame(1);
    n_cmp++;
    if (data !== 24'h123456 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_ready got %h/%b want 123456/1", data, valid);
    end
    n_cmp++;
    if (n_ovr != o0) begin n_fail++; $display("FAIL commit_ready_ovr got %0d want 0", n_ovr - o0); end
    n_cmp++;
    if (q.size() != 0) begin n_fail++; $display("FAIL commit_ready_drain got %0d want 0", q.size()); end
    rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    rdy = 1'b1;
    send_bits(32'h00ABC, 12, -1);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", busy); end
    rst_n = 1'b0;
    cs = 1'b1;
    sck = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({data, valid, busy, ferr, ovr} !== 28'h0) begin
      n_fail++;
      $display("FAIL mid_reset got %h %b want 000000 0000", data, {valid, busy, ferr, ovr});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    q.push_back(24'h0F0F0F);
    send_bits(32'h0F0F0F, 24, -1);
    end_frame(0);
    wait_drain();
    n_cmp++;
    if (q.size() != 0 || data !== 24'h0F0F0F) begin
      n_fail++;
      $display("FAIL after_reset got %h pending %0d want 0f0f0f pending 0", data, q.size());
    end
  endtask

  task automatic test_glitch();
    int f0 = n_ferr;
    rdy = 1'b1;
    if (GLITCH_ERR == 0) q.push_back(24'h800001);
    send_bits(32'h800001, 24, 12);
    end_frame(0);
    wait_drain();
    n_cmp++;
    if (n_ferr - f0 != GLITCH_ERR) begin
      n_fail++;
      $display("FAIL glitch_err got %0d want %0d", n_ferr - f0, GLITCH_ERR);
    end
    n_cmp++;
    if (q.size() != 0 || data !== (GLITCH_ERR != 0 ? 24'h0F0F0F : 24'h800001)) begin
      n_fail++;
      $display("FAIL glitch_data got %h pending %0d", data, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_error();
    test_overrun();
    test_commit_ready();
    test_reset_mid();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
